shift_scheduler: RTL and testbench
==================================

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
- REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits and the shift amount at 5 bits.
- REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
- REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
- REQ-005 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
- REQ-006 req0_x / req1_x  input  32  operand.
- REQ-007 req0_s / req1_s  input  5  shift amount, 0..31.
- REQ-008 req0_op / req1_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- REQ-009 rsp_valid  output  1  result available.
- REQ-010 rsp_ready  input  1  consumer accepts the result.
- REQ-011 rsp_z  output  32  result.
- REQ-012 rsp_id  output  1  index of the requester that issued the result.
- REQ-013 sh_x / sh_s / sh_left / sh_log  output  32/5/1/1  drive to the shared combinational shifter.
- REQ-014 sh_z  input  32  shifter result, valid in the same cycle as the sh_* drive.
- REQ-015 busy  output  1  high whenever state is not IDLE.

Function
- REQ-016 State machine SHALL have four states: IDLE, PASS1, PASS2, RESP. Exactly one operation SHALL be in flight at any time.
- REQ-017 In IDLE, req0_ready and req1_ready SHALL be driven high only for the granted requester, combinationally from the valids and the priority pointer. In all other states both SHALL be 0.
- REQ-018 Arbitration SHALL be round-robin:
  - if only one valid is high, that requester is granted;
  - if both are high, the requester named by the pointer is granted;
  - after every grant, the pointer SHALL point to the non-granted requester.
- REQ-019 On a grant (valid and ready both high), the block SHALL latch x, s, op and id, then go IDLE -> PASS1.
- REQ-020 PASS1 shifter drive SHALL be sh_x = latched x and sh_s = latched s, with the control bits below:

  | op  | sh_left | sh_log |
  |-----|---------|--------|
  | SLL | 1       | 1      |
  | SRL | 0       | 1      |
  | SRA | 0       | 0      |
  | ROR | 0       | 1      |

  sh_z SHALL be captured into the accumulator.
- REQ-021 After PASS1: ROR SHALL go to PASS2; all other ops SHALL go to RESP.
- REQ-022 PASS2 shifter drive SHALL be sh_x = latched x, sh_s = (32 - s) mod 32 (5-bit two's complement of s), sh_left = 1, sh_log = 1. The accumulator SHALL be updated to accumulator OR sh_z. Next state SHALL be RESP.
- REQ-023 ROR with s = 0 SHALL still execute both passes; the result equals x.
- REQ-024 In RESP, rsp_valid SHALL be 1 and rsp_z/rsp_id SHALL equal the accumulator and the latched id, held stable until rsp_ready is sampled high. On that handshake the next state SHALL be IDLE.
- REQ-025 No new request SHALL be accepted in the cycle of the response handshake; the earliest next grant is the following cycle.
- REQ-026 Latency from grant cycle N: rsp_valid SHALL first assert in cycle N+2 for SLL/SRL/SRA and N+3 for ROR.
- REQ-027 Outside PASS1/PASS2, the sh_* outputs SHALL be all zeros.
- REQ-028 A requester's valid dropping while not granted SHALL have no effect. Request fields SHALL be ignored except in the grant cycle.

Reset
- REQ-029 While reset is low at a clock edge, the block SHALL set:
  - state = IDLE;
  - pointer = requester 0;
  - accumulator, latched fields, rsp_z, rsp_id, rsp_valid, busy = 0.
- REQ-030 Reset asserted mid-operation (PASS1/PASS2/RESP) SHALL discard the operation with no response issued. req*_ready SHALL be 0 during the reset cycle.

Verification
- REQ-031 req0 SRA, x = 0x80000000, s = 4 -> rsp_z = 0xF8000000, rsp_id = 0, rsp_valid first in cycle N+2.
- REQ-032 req1 ROR, x = 0x00000001, s = 1 -> PASS2 drives sh_s = 31; rsp_z = 0x80000000, rsp_id = 1, rsp_valid first in cycle N+3.
- REQ-033 Both valid continuously after reset, req0 SLL x = 0x1 s = 3, req1 SRL x = 0x80 s = 7 -> grants alternate 0,1,0,1; responses alternate 0x00000008 (id 0) and 0x00000001 (id 1).
- REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_z/rsp_id stable, both req*_ready = 0, busy = 1; IDLE is re-entered one cycle after rsp_ready rises.
- REQ-035 Reset pulsed low during PASS2 of a ROR -> no rsp_valid; next cycle all outputs are 0, and the subsequent grant goes to req0 if both are valid.
- REQ-036 ROR, x = 0x12345678, s = 0 -> rsp_z = 0x12345678.

Source files
------------

// File: rtl/shift_scheduler.sv
// Two-requester scheduler for a shared 32-bit combinational shifter.
// One operation in flight: grant, one or two shifter passes, then hold the response.
module shift_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic [4:0]  req0_s,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    input  logic [4:0]  req1_s,
    input  logic [1:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic        rsp_id,
    output logic [31:0] sh_x,
    output logic [4:0]  sh_s,
    output logic        sh_left,
    output logic        sh_log,
    input  logic [31:0] sh_z,
    output logic        busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned OW = 2;

    localparam logic [OW-1:0] OP_SLL = 2'b00;
    localparam logic [OW-1:0] OP_SRA = 2'b10;
    localparam logic [OW-1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          ptr_q,   ptr_d;
    logic [DW-1:0] x_q,     x_d;
    logic [SW-1:0] s_q,     s_d;
    logic [OW-1:0] op_q,    op_d;
    logic          id_q,    id_d;
    logic [DW-1:0] acc_q,   acc_d;

    logic          any_valid;
    logic          gnt_id;
    logic          accept;

    // Round-robin pick: a lone valid wins, a tie goes to the pointer
    always_comb begin
        any_valid = req0_valid | req1_valid;
        gnt_id    = (req0_valid & req1_valid) ? ptr_q : req1_valid;
        accept    = (state_q == IDLE) & reset & any_valid;
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            x_q     <= '0;
            s_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
            s_q     <= s_d;
            op_q    <= op_d;
            id_q    <= id_d;
            acc_q   <= acc_d;
        end
    end

    // Next state, operand capture and accumulator update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        x_d     = x_q;
        s_d     = s_q;
        op_d    = op_q;
        id_d    = id_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = gnt_id ? req1_x  : req0_x;
                    s_d     = gnt_id ? req1_s  : req0_s;
                    op_d    = gnt_id ? req1_op : req0_op;
                    id_d    = gnt_id;
                    ptr_d   = ~gnt_id;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                acc_d   = sh_z;
                state_d = (op_q == OP_ROR) ? PASS2 : RESP;
            end
            PASS2: begin
                acc_d   = acc_q | sh_z;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state: handshakes, shifter drive, response
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        sh_x       = '0;
        sh_s       = '0;
        sh_left    = 1'b0;
        sh_log     = 1'b0;
        rsp_valid  = 1'b0;
        rsp_z      = acc_q;
        rsp_id     = id_q;
        busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (reset) begin
                    req0_ready = req0_valid & ~gnt_id;
                    req1_ready = req1_valid & gnt_id;
                end
            end
            PASS1: begin
                sh_x    = x_q;
                sh_s    = s_q;
                sh_left = (op_q == OP_SLL);
                sh_log  = (op_q != OP_SRA);
            end
            PASS2: begin
                // Left by (32 - s) mod 32 supplies the wrapped bits of the rotate
                sh_x    = x_q;
                sh_s    = SW'(~s_q + SW'(1));
                sh_left = 1'b1;
                sh_log  = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_scheduler.sv
// Bench for shift_scheduler: behavioural shifter, grant-time scoreboard, directed and random traffic.
module tb_shift_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_x, req1_x;
    logic [4:0]  req0_s, req1_s;
    logic [1:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_z;
    logic [31:0] sh_x, sh_z;
    logic [4:0]  sh_s;
    logic        sh_left, sh_log, busy;

    always #5 clock = ~clock;

    shift_scheduler dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_s(req0_s), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_s(req1_s), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_id(rsp_id),
        .sh_x(sh_x), .sh_s(sh_s), .sh_left(sh_left), .sh_log(sh_log), .sh_z(sh_z),
        .busy(busy)
    );

    // Shared combinational shifter
    assign sh_z = sh_left ? (sh_x << sh_s)
                : (sh_log ? (sh_x >> sh_s) : 32'($signed(sh_x) >>> sh_s));

    typedef struct {
        logic [31:0] x;
        logic [4:0]  s;
        logic [1:0]  op;
        logic        id;
        int          gcyc;
    } txn_t;

    txn_t        sb[$];
    int          glog[$];
    int          gcnt[2];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_z;
    logic        last_id;
    logic        rnd_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] s, input logic [1:0] op);
        logic [63:0] dbl;
        case (op)
            2'b00:   return x << s;
            2'b01:   return x >> s;
            2'b10:   return 32'($signed(x) >>> s);
            default: begin
                dbl = {x, x} >> s;
                return dbl[31:0];
            end
        endcase
    endfunction

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: record grants, check shifter drive, latency, hold and results
    initial begin
        logic        pv;
        logic        prr;
        logic [31:0] pz;
        logic        pid;
        logic [5:0]  neg6;
        txn_t        t;
        pv = 1'b0; prr = 1'b1; pz = '0; pid = 1'b0;
        gcnt[0] = 0; gcnt[1] = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
            end else begin
                if (req0_valid && req1_valid)
                    check("single_grant", 32'(req0_ready & req1_ready), 32'd0);
                if (pv && !prr) begin
                    check("hold_valid", 32'(rsp_valid), 32'd1);
                    check("hold_z", rsp_z, pz);
                    check("hold_id", 32'(rsp_id), 32'(pid));
                end
                if (!busy)
                    check("sh_idle", 32'({(|sh_x), sh_s, sh_left, sh_log}), 32'd0);
                if (sb.size() > 0) begin
                    if (cyc == sb[0].gcyc + 1) begin
                        check("p1_x", sh_x, sb[0].x);
                        check("p1_s", 32'(sh_s), 32'(sb[0].s));
                        check("p1_ctl", 32'({sh_left, sh_log}),
                              32'({sb[0].op == 2'b00, sb[0].op != 2'b10}));
                    end
                    if (cyc == sb[0].gcyc + 2 && sb[0].op == 2'b11) begin
                        neg6 = 6'd32 - 6'(sb[0].s);
                        check("p2_x", sh_x, sb[0].x);
                        check("p2_s", 32'(sh_s), 32'(neg6[4:0]));
                        check("p2_ctl", 32'({sh_left, sh_log}), 32'd3);
                    end
                end
                if (rsp_valid && !pv) begin
                    if (sb.size() == 0) check("spurious_rsp", 32'd1, 32'd0);
                    else check("latency", 32'(cyc - sb[0].gcyc), (sb[0].op == 2'b11) ? 32'd3 : 32'd2);
                end
                if (rsp_valid && rsp_ready && sb.size() > 0) begin
                    t = sb.pop_front();
                    check("rsp_z", rsp_z, model(t.x, t.s, t.op));
                    check("rsp_id", 32'(rsp_id), 32'(t.id));
                    last_z  = rsp_z;
                    last_id = rsp_id;
                end
                if (req0_valid && req0_ready) begin
                    sb.push_back('{x: req0_x, s: req0_s, op: req0_op, id: 1'b0, gcyc: cyc});
                    glog.push_back(0);
                    gcnt[0]++;
                end
                if (req1_valid && req1_ready) begin
                    sb.push_back('{x: req1_x, s: req1_s, op: req1_op, id: 1'b1, gcyc: cyc});
                    glog.push_back(1);
                    gcnt[1]++;
                end
            end
            pv  = rsp_valid & reset;
            prr = rsp_ready;
            pz  = rsp_z;
            pid = rsp_id;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] x, input logic [4:0] s, input logic [1:0] op);
        if (n == 0) begin
            req0_valid = v; req0_x = x; req0_s = s; req0_op = op;
        end else begin
            req1_valid = v; req1_x = x; req1_s = s; req1_op = op;
        end
    endtask

    // Present one request until granted, then drop it and scramble the fields
    task automatic send(input int n, input logic [31:0] x, input logic [4:0] s, input logic [1:0] op);
        int start = gcnt[n];
        int b = 0;
        set_req(n, 1'b1, x, s, op);
        while (gcnt[n] == start && b < 50) begin
            tick();
            b++;
        end
        if (gcnt[n] == start) check("grant_timeout", 32'd0, 32'd1);
        set_req(n, 1'b0, $urandom, 5'($urandom), 2'($urandom));
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() > 0 && b < 100) begin
            tick();
            b++;
        end
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int b;
        reset = 1'b0; rsp_ready = 1'b1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        tick(); tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_z", rsp_z, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        // SRA sign extension
        send(0, 32'h8000_0000, 5'd4, 2'b10);
        drain();
        check("sra_vec_z", last_z, 32'hF800_0000);
        check("sra_vec_id", 32'(last_id), 32'd0);

        // ROR by 1 from requester 1
        send(1, 32'h0000_0001, 5'd1, 2'b11);
        drain();
        check("ror_vec_z", last_z, 32'h8000_0000);
        check("ror_vec_id", 32'(last_id), 32'd1);

        // ROR by 0 still runs both passes and returns x
        send(0, 32'h1234_5678, 5'd0, 2'b11);
        drain();
        check("ror0_vec_z", last_z, 32'h1234_5678);

        // Reset with both requesters valid, then alternate 0,1,0,1
        reset = 1'b0;
        set_req(0, 1'b1, 32'h1, 5'd3, 2'b00);
        set_req(1, 1'b1, 32'h80, 5'd7, 2'b01);
        tick();
        reset = 1'b1;
        glog.delete();
        b = 0;
        while (glog.size() < 4 && b < 60) begin
            tick();
            b++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("alt_count", 32'(glog.size()), 32'd4);
        if (glog.size() >= 4) begin
            check("alt_g0", 32'(glog[0]), 32'd0);
            check("alt_g1", 32'(glog[1]), 32'd1);
            check("alt_g2", 32'(glog[2]), 32'd0);
            check("alt_g3", 32'(glog[3]), 32'd1);
        end
        drain();

        // Consumer stall in RESP
        rsp_ready = 1'b0;
        send(0, 32'h5, 5'd2, 2'b00);
        b = 0;
        while (!rsp_valid && b < 10) begin
            tick();
            b++;
        end
        check("stall_reach_resp", 32'(rsp_valid), 32'd1);
        set_req(1, 1'b1, 32'hF0, 5'd4, 2'b01);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_z", rsp_z, 32'h14);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("stall_idle_busy", 32'(busy), 32'd0);
        check("stall_idle_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        drain();

        // Reset during PASS2 of a ROR discards it; pointer returns to requester 0
        send(0, 32'hF0F0_1234, 5'd4, 2'b11);
        tick();
        check("kill_in_pass2", 32'({busy, sh_left, rsp_valid}), 32'b110);
        reset = 1'b0;
        tick();
        sb.delete();
        reset = 1'b1;
        check("kill_rsp_valid", 32'(rsp_valid), 32'd0);
        check("kill_rsp_z", rsp_z, 32'd0);
        check("kill_rsp_id", 32'(rsp_id), 32'd0);
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_sh", 32'({(|sh_x), sh_s, sh_left, sh_log}), 32'd0);
        set_req(0, 1'b1, 32'hA5A5_0001, 5'd9, 2'b11);
        set_req(1, 1'b1, 32'h0000_FFFF, 5'd2, 2'b00);
        #1;
        check("kill_next_grant", 32'({req0_ready, req1_ready}), 32'b10);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Random traffic with a randomly stalling consumer
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 1)), $urandom, 5'($urandom), 2'($urandom));
        end
        drain();
        rnd_ready = 1'b0;
        #2;
        rsp_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
